ifm_sparse_chunk_encoder: RTL and testbench
===========================================

# ifm_sparse_chunk_encoder

Write-side producer for the double-buffered IFM chunk store. It accepts dense IFM bytes one bus beat per cycle and builds one sparsemap bit per byte (1 = nonzero). It compacts the nonzero bytes of each beat and issues the store's write beats: sparsemap, nonzero data, valid, beat count and bank select. It fills the two banks alternately and stalls upstream when the target bank has not yet been released by the compute side.

## Interface
- BUS_SIZE, default `BUS_SIZE: bytes per input beat and sparsemap bits per write beat.
- CHUNK_SIZE, default `CHUNK_SIZE: bytes per chunk. Must be a multiple of BUS_SIZE.
- WR_DAT_CYC_NUM, localparam = CHUNK_SIZE/BUS_SIZE: beats per chunk, at least 2.
- clk_i  in  1  clock. One clock for the whole block.
- rst_i  in  1  synchronous, active-high reset.
- in_data_i  in  [BUS_SIZE-1:0][7:0]  dense IFM bytes. Byte 0 is the lowest chunk position.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when in_valid_i && in_ready_o.
- bank_release_i  in  [1:0]  one-cycle pulse: the compute side has finished bank n.
- wr_sparsemap_o  out  [BUS_SIZE-1:0]  nonzero map of the beat.
- wr_nonzero_data_o  out  [BUS_SIZE-1:0][7:0]  compacted nonzero bytes. Lower lanes first, zero-padded.
- wr_valid_o  out  1  write beat valid.
- wr_count_o  out  $clog2(WR_DAT_CYC_NUM)  beat index within the chunk.
- wr_sel_o  out  1  target bank of the write beat.
- bank_full_o  out  [1:0]  bank holds a complete, unreleased chunk.
- chunk_done_o  out  1  one-cycle pulse, coincident with the last write beat of a chunk.
- chunk_nz_cnt_o  out  $clog2(CHUNK_SIZE)+1  total nonzero bytes in the chunk. Valid with chunk_done_o and held until the next chunk_done_o.

## Operation
- State: cur_bank_r, the bank being filled. beat_cnt_r, 0..WR_DAT_CYC_NUM-1. bank_full_r[1:0]. nz_acc_r, the running popcount.
- in_ready_o = !rst_i && !bank_full_r[cur_bank_r].
- Accept:
  - Register the compacted beat.
  - wr_sel_o = cur_bank_r, wr_count_o = beat_cnt_r.
  - beat_cnt_r increments.
- Compaction: lane k of wr_nonzero_data_o is the k-th nonzero byte of the beat, counted in ascending lane order. Lanes at or above the popcount are 0.
- Last beat (beat_cnt_r == WR_DAT_CYC_NUM-1) accepted:
  - beat_cnt_r wraps to 0.
  - bank_full_r[cur_bank_r] is set.
  - cur_bank_r toggles.
  - The output beat carries chunk_done_o = 1 and chunk_nz_cnt_o = nz_acc_r + popcount(beat).
  - nz_acc_r clears.
- Release: bank_release_i[n] clears bank_full_r[n] next cycle.
  - A release of a bank that is not full is ignored.
  - A release and a set in the same cycle on the same bank is impossible, because a full bank cannot be written. A release on one bank and a set on the other in the same cycle both take effect.
- Both banks full: in_ready_o = 0 until a release arrives. The first release unblocks cur_bank_r, which after the toggle is the older chunk's bank.
- Reset values: every output 0, cur_bank_r 0, beat_cnt_r 0, bank_full_r 00, nz_acc_r 0. A reset mid-chunk discards the partial chunk, and no chunk_done_o is issued.

## Timing
- Latency is 1 cycle: a beat accepted at edge t appears on the wr_* outputs for exactly the cycle after t, with wr_valid_o = 1.
- Back-to-back acceptance gives wr_valid_o continuously high, one beat per cycle.
- in_ready_o is combinational from registered state and rst_i only. It has no path from in_valid_i.
- A release pulse at edge t allows acceptance into that bank at edge t+1, so a bank is re-filled 1 cycle after release.
- bank_full_o for a completed chunk rises in the same cycle as its chunk_done_o.

## Structure
- Package ifm_enc_pkg holds:
  - the beat typedefs for byte vector and sparsemap;
  - the WR_DAT_CYC_NUM and count-width constants.
- Sub-module ifm_beat_compactor is purely combinational. It takes in_data_i and produces the sparsemap, the compacted bytes and the popcount. Implement it as a prefix-sum lane select.
- Top level holds the counters, the bank flags and the output register.

## Test plan
All scenarios use BUS_SIZE=8, CHUNK_SIZE=32, so WR_DAT_CYC_NUM=4.
- Compaction. Input bytes {0,5,0,0,9,0,0,3}, lane0 first.
  - wr_sparsemap_o = 8'b10010010.
  - wr_nonzero_data_o lanes = {5,9,3,0,0,0,0,0}.
  - Valid one cycle after acceptance.
- Chunk and bank toggle. Stream 4 beats with 2, 0, 8 and 1 nonzeros.
  - wr_count_o = 0,1,2,3 and wr_sel_o = 0 on all four.
  - chunk_done_o on beat 3 with chunk_nz_cnt_o = 11.
  - bank_full_o = 01.
  - The next beat has wr_sel_o = 1.
- Backpressure. Stream 8 beats with no release.
  - After the 8th beat, bank_full_o = 11 and in_ready_o = 0.
  - Hold valid 5 cycles: no wr_valid_o appears.
- Release. With both banks full, pulse bank_release_i = 01.
  - in_ready_o = 1 the next cycle.
  - The next beat has wr_sel_o = 0 and wr_count_o = 0.
  - A spurious bank_release_i = 10 while bank 1 is not full has no effect.
- Simultaneous events.
  - The last beat into bank 1 is accepted in the same cycle as a bank_release_i[0] pulse: bank_full_o becomes 10.
  - Acceptance continues into bank 0 without a stall.
- Reset mid-chunk. Assert rst_i after 2 beats.
  - All outputs are 0 and in_ready_o = 0 during reset.
  - After reset, the first beat has wr_count_o = 0 and wr_sel_o = 0.
  - No chunk_done_o for the partial chunk.

Source files
------------

// File: rtl/ifm_enc_pkg.sv
// rtl/ifm_enc_pkg.sv - shared widths and beat types for the IFM sparse chunk encoder
//
// Default bus/chunk geometry, the beats-per-chunk and counter-width constants
// derived from it, and the byte-vector / sparsemap beat types.

`ifndef BUS_SIZE
`define BUS_SIZE 8
`endif
`ifndef CHUNK_SIZE
`define CHUNK_SIZE 32
`endif

package ifm_enc_pkg;

  localparam int BUS_SIZE_DEF   = `BUS_SIZE;
  localparam int CHUNK_SIZE_DEF = `CHUNK_SIZE;
  localparam int WR_DAT_CYC_NUM = CHUNK_SIZE_DEF / BUS_SIZE_DEF;
  localparam int CNT_W          = $clog2(WR_DAT_CYC_NUM);
  localparam int NZ_CNT_W       = $clog2(CHUNK_SIZE_DEF) + 1;
  localparam int POP_W          = $clog2(BUS_SIZE_DEF + 1);

  typedef logic [BUS_SIZE_DEF-1:0][7:0] beat_bytes_t;
  typedef logic [BUS_SIZE_DEF-1:0]      beat_map_t;

endpackage

// File: rtl/ifm_beat_compactor.sv
// rtl/ifm_beat_compactor.sv - combinational nonzero compaction of one dense beat
//
// Ports:
//   data_i      dense bytes, lane 0 lowest
//   sparsemap_o one bit per lane, 1 = byte nonzero
//   nz_data_o   nonzero bytes packed towards lane 0, upper lanes zero
//   popcount_o  number of nonzero bytes in the beat

module ifm_beat_compactor
  import ifm_enc_pkg::*;
#(
  parameter int BUS_SIZE = BUS_SIZE_DEF
) (
  input  logic [BUS_SIZE-1:0][7:0]         data_i,
  output logic [BUS_SIZE-1:0]              sparsemap_o,
  output logic [BUS_SIZE-1:0][7:0]         nz_data_o,
  output logic [$clog2(BUS_SIZE+1)-1:0]    popcount_o
);

  localparam int PW = $clog2(BUS_SIZE + 1);

  // prefix[k] = number of nonzero lanes strictly below lane k; a nonzero
  // byte at lane k therefore lands on output lane prefix[k].
  logic [BUS_SIZE:0][PW-1:0] prefix;

  always_comb begin
    prefix      = '0;
    sparsemap_o = '0;
    nz_data_o   = '0;
    for (int k = 0; k < BUS_SIZE; k++) begin
      sparsemap_o[k] = |data_i[k];
      prefix[k+1]    = prefix[k] + PW'(sparsemap_o[k]);
    end
    // Output lane j can only be fed from input lanes k >= j; exactly one
    // match exists per populated lane, so an AND-OR select suffices.
    for (int j = 0; j < BUS_SIZE; j++) begin
      for (int k = j; k < BUS_SIZE; k++) begin
        if (sparsemap_o[k] && (prefix[k] == PW'(j))) begin
          nz_data_o[j] = nz_data_o[j] | data_i[k];
        end
      end
    end
    popcount_o = prefix[BUS_SIZE];
  end

endmodule

// File: rtl/ifm_sparse_chunk_encoder.sv
// rtl/ifm_sparse_chunk_encoder.sv - sparse write-side producer for the double-buffered IFM chunk store
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   in_data_i/valid/ready dense input beats, one per cycle
//   bank_release_i        per-bank pulse from the compute side
//   wr_*                  registered write beat to the store (map, packed data,
//                         valid, beat index, bank select)
//   bank_full_o           bank holds a complete unreleased chunk
//   chunk_done_o          pulse with the last write beat of a chunk
//   chunk_nz_cnt_o        nonzero total of the last completed chunk (held)

module ifm_sparse_chunk_encoder
  import ifm_enc_pkg::*;
#(
  parameter  int BUS_SIZE       = `BUS_SIZE,
  parameter  int CHUNK_SIZE     = `CHUNK_SIZE,
  localparam int WR_DAT_CYC_NUM = CHUNK_SIZE / BUS_SIZE,
  localparam int CNT_W          = $clog2(WR_DAT_CYC_NUM),
  localparam int NZ_W           = $clog2(CHUNK_SIZE) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [BUS_SIZE-1:0][7:0]  in_data_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [1:0]                bank_release_i,
  output logic [BUS_SIZE-1:0]       wr_sparsemap_o,
  output logic [BUS_SIZE-1:0][7:0]  wr_nonzero_data_o,
  output logic                      wr_valid_o,
  output logic [CNT_W-1:0]          wr_count_o,
  output logic                      wr_sel_o,
  output logic [1:0]                bank_full_o,
  output logic                      chunk_done_o,
  output logic [NZ_W-1:0]           chunk_nz_cnt_o
);

  localparam int PW = $clog2(BUS_SIZE + 1);

  logic             cur_bank_r;
  logic [CNT_W-1:0] beat_cnt_r;
  logic [1:0]       bank_full_r;
  logic [NZ_W-1:0]  nz_acc_r;

  logic                     accept;
  logic                     last_beat;
  logic [1:0]               set_mask;
  logic [BUS_SIZE-1:0]      beat_map;
  logic [BUS_SIZE-1:0][7:0] beat_nz;
  logic [PW-1:0]            beat_pop;
  logic [NZ_W-1:0]          beat_pop_ext;

  ifm_beat_compactor #(
    .BUS_SIZE (BUS_SIZE)
  ) u_compactor (
    .data_i      (in_data_i),
    .sparsemap_o (beat_map),
    .nz_data_o   (beat_nz),
    .popcount_o  (beat_pop)
  );

  // Ready depends only on registered bank state and reset, never on valid.
  assign in_ready_o   = !rst_i && !bank_full_r[cur_bank_r];
  assign accept       = in_valid_i && in_ready_o;
  assign last_beat    = (beat_cnt_r == CNT_W'(WR_DAT_CYC_NUM - 1));
  assign beat_pop_ext = NZ_W'(beat_pop);
  assign bank_full_o  = bank_full_r;

  always_comb begin
    set_mask = '0;
    if (accept && last_beat) begin
      set_mask[cur_bank_r] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_bank_r        <= 1'b0;
      beat_cnt_r        <= '0;
      bank_full_r       <= '0;
      nz_acc_r          <= '0;
      wr_sparsemap_o    <= '0;
      wr_nonzero_data_o <= '0;
      wr_valid_o        <= 1'b0;
      wr_count_o        <= '0;
      wr_sel_o          <= 1'b0;
      chunk_done_o      <= 1'b0;
      chunk_nz_cnt_o    <= '0;
    end else begin
      wr_valid_o   <= accept;
      chunk_done_o <= accept && last_beat;
      // A full bank is never written, so a set and a release can never hit
      // the same bit; releasing an empty bank clears an already-clear bit.
      bank_full_r  <= (bank_full_r & ~bank_release_i) | set_mask;

      if (accept) begin
        wr_sparsemap_o    <= beat_map;
        wr_nonzero_data_o <= beat_nz;
        wr_count_o        <= beat_cnt_r;
        wr_sel_o          <= cur_bank_r;
        if (last_beat) begin
          beat_cnt_r     <= '0;
          cur_bank_r     <= ~cur_bank_r;
          nz_acc_r       <= '0;
          chunk_nz_cnt_o <= nz_acc_r + beat_pop_ext;
        end else begin
          beat_cnt_r <= beat_cnt_r + CNT_W'(1);
          nz_acc_r   <= nz_acc_r + beat_pop_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifm_sparse_chunk_encoder.sv
// tb/tb_ifm_sparse_chunk_encoder.sv - self-checking bench for ifm_sparse_chunk_encoder

module tb_ifm_sparse_chunk_encoder;
  import ifm_enc_pkg::*;

  localparam int BUS   = 8;
  localparam int CHUNK = 32;
  localparam int BEATS = CHUNK / BUS;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [7:0][7:0]  in_data_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       bank_release_i;
  logic [7:0]       wr_sparsemap_o;
  logic [7:0][7:0]  wr_nonzero_data_o;
  logic             wr_valid_o;
  logic [1:0]       wr_count_o;
  logic             wr_sel_o;
  logic [1:0]       bank_full_o;
  logic             chunk_done_o;
  logic [5:0]       chunk_nz_cnt_o;

  always #5 clk_i = ~clk_i;

  ifm_sparse_chunk_encoder #(
    .BUS_SIZE   (BUS),
    .CHUNK_SIZE (CHUNK)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .in_data_i         (in_data_i),
    .in_valid_i        (in_valid_i),
    .in_ready_o        (in_ready_o),
    .bank_release_i    (bank_release_i),
    .wr_sparsemap_o    (wr_sparsemap_o),
    .wr_nonzero_data_o (wr_nonzero_data_o),
    .wr_valid_o        (wr_valid_o),
    .wr_count_o        (wr_count_o),
    .wr_sel_o          (wr_sel_o),
    .bank_full_o       (bank_full_o),
    .chunk_done_o      (chunk_done_o),
    .chunk_nz_cnt_o    (chunk_nz_cnt_o)
  );

  int tests_run = 0;
  int fail_cnt  = 0;

  // Reference model state (store-level view: which bank, which beat, which banks are full)
  int          m_bank = 0;
  int          m_cnt  = 0;
  int          m_acc  = 0;
  logic [1:0]  m_full = 2'b00;

  // Expected outputs after the most recent edge
  logic        e_valid = 1'b0;
  logic        e_done  = 1'b0;
  logic        e_sel   = 1'b0;
  logic [7:0]  e_sm    = '0;
  logic [7:0][7:0] e_data = '0;
  int          e_cnt   = 0;
  int          e_nz    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0][7:0] gen_beat(input int nz);
    int idx[8];
    int j;
    int t;
    logic [7:0][7:0] b;
    for (int i = 0; i < 8; i++) idx[i] = i;
    for (int i = 7; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = idx[i]; idx[i] = idx[j]; idx[j] = t;
    end
    b = '0;
    for (int i = 0; i < nz; i++) b[idx[i]] = 8'($urandom_range(255, 1));
    return b;
  endfunction

  // One clock: apply inputs, check ready, advance model and DUT, check outputs.
  task automatic cycle(input logic [7:0][7:0] d, input logic v, input logic [1:0] rel, input logic r);
    logic       acc;
    int         pop;
    logic [1:0] setm;
    in_data_i      = d;
    in_valid_i     = v;
    bank_release_i = rel;
    rst_i          = r;
    #1;
    chk("in_ready", 64'(in_ready_o), 64'(!r && !m_full[m_bank]));
    acc = v && !r && !m_full[m_bank];
    @(posedge clk_i);
    if (r) begin
      m_bank = 0; m_cnt = 0; m_acc = 0; m_full = 2'b00;
      e_valid = 1'b0; e_done = 1'b0; e_sel = 1'b0;
      e_sm = '0; e_data = '0; e_cnt = 0; e_nz = 0;
    end else begin
      e_valid = acc;
      e_done  = 1'b0;
      setm    = 2'b00;
      if (acc) begin
        e_sm = '0; e_data = '0; pop = 0;
        for (int k = 0; k < BUS; k++) begin
          if (d[k] != 8'd0) begin
            e_sm[k]     = 1'b1;
            e_data[pop] = d[k];
            pop++;
          end
        end
        e_cnt = m_cnt;
        e_sel = m_bank[0];
        if (m_cnt == BEATS - 1) begin
          e_done       = 1'b1;
          e_nz         = m_acc + pop;
          setm[m_bank] = 1'b1;
          m_bank       = 1 - m_bank;
          m_cnt        = 0;
          m_acc        = 0;
        end else begin
          m_cnt++;
          m_acc += pop;
        end
      end
      m_full = (m_full & ~rel) | setm;
    end
    #1;
    chk("wr_valid",     64'(wr_valid_o),     64'(e_valid));
    chk("chunk_done",   64'(chunk_done_o),   64'(e_done));
    chk("chunk_nz_cnt", 64'(chunk_nz_cnt_o), 64'(e_nz));
    chk("bank_full",    64'(bank_full_o),    64'(m_full));
    if (e_valid || r) begin
      chk("wr_sparsemap", 64'(wr_sparsemap_o),    64'(e_sm));
      chk("wr_nz_data",   64'(wr_nonzero_data_o), 64'(e_data));
      chk("wr_count",     64'(wr_count_o),        64'(e_cnt));
      chk("wr_sel",       64'(wr_sel_o),          64'(e_sel));
    end
  endtask

  task automatic beat(input int nz);
    cycle(gen_beat(nz), 1'b1, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    cycle('0, 1'b0, 2'b00, 1'b1);
    cycle('0, 1'b0, 2'b00, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0][7:0] d;
    logic [1:0] rel;
    logic v;
    rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; bank_release_i = 2'b00;

    // Reset state
    do_reset();
    chk("rst_full",  64'(bank_full_o), 64'(2'b00));
    chk("rst_valid", 64'(wr_valid_o),  64'(1'b0));

    // Compaction of {0,5,0,0,9,0,0,3}, lane 0 first
    d = {8'd3, 8'd0, 8'd0, 8'd9, 8'd0, 8'd0, 8'd5, 8'd0};
    cycle(d, 1'b1, 2'b00, 1'b0);
    chk("cmp_map",   64'(wr_sparsemap_o),    64'(8'b10010010));
    chk("cmp_data",  64'(wr_nonzero_data_o), 64'h0000_0000_0003_0905);
    chk("cmp_valid", 64'(wr_valid_o),        64'(1'b1));
    cycle('0, 1'b0, 2'b00, 1'b0);

    // Chunk of 2,0,8,1 nonzeros and bank toggle
    do_reset();
    beat(2); beat(0); beat(8); beat(1);
    chk("chunk_done_c",  64'(chunk_done_o),   64'(1'b1));
    chk("chunk_nz_11",   64'(chunk_nz_cnt_o), 64'(6'd11));
    chk("chunk_full_01", 64'(bank_full_o),    64'(2'b01));
    chk("chunk_last_ct", 64'(wr_count_o),     64'(2'd3));
    beat(3);
    chk("toggle_sel1",   64'(wr_sel_o),       64'(1'b1));

    // Backpressure: two chunks, no release, then valid held against a stall
    do_reset();
    for (int i = 0; i < 2 * BEATS; i++) beat($urandom_range(8, 0));
    chk("bp_full_11", 64'(bank_full_o), 64'(2'b11));
    chk("bp_ready_0", 64'(in_ready_o),  64'(1'b0));
    for (int i = 0; i < 5; i++) beat(4);

    // Release bank 0, refill it, then real and spurious bank 1 releases
    cycle('0, 1'b0, 2'b01, 1'b0);
    chk("rel_ready_1", 64'(in_ready_o), 64'(1'b1));
    beat(5);
    chk("rel_sel_0",   64'(wr_sel_o),   64'(1'b0));
    chk("rel_count_0", 64'(wr_count_o), 64'(2'd0));
    cycle('0, 1'b0, 2'b10, 1'b0);
    cycle('0, 1'b0, 2'b10, 1'b0);
    chk("spur_full_00", 64'(bank_full_o), 64'(2'b00));

    // Last beat into bank 1 coincides with a release of bank 0
    do_reset();
    for (int i = 0; i < BEATS; i++) beat(1);
    for (int i = 0; i < BEATS - 1; i++) beat(2);
    cycle(gen_beat(3), 1'b1, 2'b01, 1'b0);
    chk("sim_full_10", 64'(bank_full_o),  64'(2'b10));
    chk("sim_done",    64'(chunk_done_o), 64'(1'b1));
    beat(6);
    chk("sim_valid",   64'(wr_valid_o),   64'(1'b1));
    chk("sim_sel_0",   64'(wr_sel_o),     64'(1'b0));

    // Reset mid-chunk with valid still asserted
    do_reset();
    beat(4); beat(4);
    cycle(gen_beat(5), 1'b1, 2'b00, 1'b1);
    cycle(gen_beat(5), 1'b1, 2'b00, 1'b1);
    chk("mid_rst_done", 64'(chunk_done_o), 64'(1'b0));
    beat(2);
    chk("mid_count_0", 64'(wr_count_o), 64'(2'd0));
    chk("mid_sel_0",   64'(wr_sel_o),   64'(1'b0));
    beat(2); beat(2);
    chk("mid_no_done", 64'(chunk_done_o), 64'(1'b0));
    beat(2);

    // Randomized traffic with random releases and rare resets
    for (int i = 0; i < 600; i++) begin
      v   = ($urandom_range(3, 0) != 0);
      rel = ($urandom_range(5, 0) == 0) ? 2'($urandom_range(3, 0)) : 2'b00;
      d   = gen_beat($urandom_range(8, 0));
      cycle(d, v, rel, ($urandom_range(199, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
